// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART packet parser and builder: header field
// widths, builder FSM states and header pack/unpack helpers.
package uart_pkt_pkg;

  localparam int HDR_INSTR_W = 4;
  localparam int HDR_LEN_W   = 4;
  localparam int MAX_PAYLOAD = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } builder_state_e;

  typedef struct packed {
    logic [HDR_INSTR_W-1:0] instr;
    logic [HDR_LEN_W-1:0]   len;
  } hdr_t;

  function automatic logic [HDR_INSTR_W+HDR_LEN_W-1:0] hdr_pack(
    input logic [HDR_INSTR_W-1:0] instr,
    input logic [HDR_LEN_W-1:0]   len
  );
    return {instr, len};
  endfunction

  function automatic hdr_t hdr_unpack(input logic [HDR_INSTR_W+HDR_LEN_W-1:0] hdr);
    return hdr_t'(hdr);
  endfunction

endpackage

// File: rtl/uart_packet_builder.sv
// Serialises response descriptors plus buffered payload into header+payload
// byte packets on the UART TX valid/ready interface.
module uart_packet_builder
  import uart_pkt_pkg::*;
#(
  parameter int MAX_LEN = MAX_PAYLOAD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rsp_empty,
  input  logic [3:0] rsp_instr,
  input  logic [7:0] rsp_len,
  output logic       rsp_rd,
  input  logic [7:0] dat_count,
  input  logic [7:0] dat_byte,
  output logic       dat_rd,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       pkt_error
);

  localparam logic [7:0]           MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [HDR_LEN_W-1:0] LEN_ONE   = HDR_LEN_W'(1);
  localparam logic [HDR_LEN_W-1:0] LEN_ZERO  = '0;

  builder_state_e         state_q, state_d;
  logic [HDR_INSTR_W-1:0] cur_instr_q;
  logic [HDR_LEN_W-1:0]   cur_len_q;
  logic [HDR_LEN_W-1:0]   remaining_q;
  logic                   load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_instr_q <= '0;
      cur_len_q   <= '0;
      remaining_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        cur_instr_q <= rsp_instr;
        cur_len_q   <= rsp_len[HDR_LEN_W-1:0];
        remaining_q <= rsp_len[HDR_LEN_W-1:0];
      end else if (dat_rd) begin
        remaining_q <= remaining_q - LEN_ONE;
      end
    end
  end

  // tx_valid/tx_data hold until tx_valid && tx_ready; a transfer happens only on
  // that cycle, and payload pops (dat_rd) coincide exactly with payload transfers.
  always_comb begin
    state_d   = state_q;
    rsp_rd    = 1'b0;
    dat_rd    = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    pkt_error = 1'b0;
    load      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rsp_empty) begin
          if (rsp_len > MAX_LEN_B) begin
            rsp_rd    = 1'b1;
            pkt_error = 1'b1;
          end else if (dat_count >= rsp_len) begin
            rsp_rd  = 1'b1;
            load    = 1'b1;
            state_d = ST_HEADER;
          end
        end
      end
      ST_HEADER: begin
        tx_valid = 1'b1;
        tx_data  = hdr_pack(cur_instr_q, cur_len_q);
        if (tx_ready) state_d = (cur_len_q == LEN_ZERO) ? ST_IDLE : ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        // Empty data FIFO mid-packet is an upstream fault: stall and flag it.
        if (dat_count == 8'd0) begin
          pkt_error = 1'b1;
        end else begin
          tx_valid = 1'b1;
          tx_data  = dat_byte;
          if (tx_ready) begin
            dat_rd = 1'b1;
            if (remaining_q == LEN_ONE) state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: doc/uart_packet_builder.md
# uart_packet_builder

Transmit-side counterpart of the UART packet parser. It pops response descriptors (instr, len) from the response command FIFO and payload bytes from the response data FIFO. It serialises each response as one header byte ({instr[3:0], len[3:0]}) followed by len payload bytes onto the UART TX byte interface, using valid/ready handshaking. A packet starts only when its whole payload is already buffered, so header and payload always go out back-to-back with no gaps caused by the block itself.

## Interface
Parameters:
- MAX_LEN, 15: largest legal payload length; must fit the 4-bit header len field.

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- rsp_empty  in  1  response command FIFO empty
- rsp_instr  in  4  head descriptor instruction (first-word-fall-through, FWFT)
- rsp_len  in  8  head descriptor payload length
- rsp_rd  out  1  one-cycle pop of the response command FIFO
- dat_count  in  8  bytes currently held in the response data FIFO
- dat_byte  in  8  head data byte (FWFT)
- dat_rd  out  1  one-cycle pop of the response data FIFO
- tx_data  out  8  byte to the UART TX
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART TX accepts the byte; a transfer occurs when tx_valid && tx_ready
- busy  out  1  high while not IDLE
- pkt_error  out  1  one-cycle error pulse

## Operation
States (enum in package): IDLE, HEADER, PAYLOAD.

IDLE:
- Condition: !rsp_empty and rsp_len > MAX_LEN.
  - Assert rsp_rd for that cycle and pulse pkt_error.
  - Descriptor is dropped; no bytes are sent; no data is popped. Stay in IDLE.
- Condition: !rsp_empty and rsp_len <= MAX_LEN and dat_count >= rsp_len.
  - Assert rsp_rd (combinational, same cycle).
  - Latch instr into cur_instr and rsp_len[3:0] into cur_len and remaining.
  - Go to HEADER.
- Otherwise: hold. No pop, tx_valid = 0.

HEADER:
- tx_valid = 1, tx_data = {cur_instr, cur_len}.
- On transfer: go to IDLE if cur_len == 0, else go to PAYLOAD.

PAYLOAD:
- tx_valid = 1, tx_data = dat_byte.
- On transfer: assert dat_rd in the same cycle and decrement remaining (4-bit counter).
- When remaining == 1 at a transfer, go to IDLE.
- If dat_count == 0 while in PAYLOAD (upstream violation):
  - Drive tx_valid = 0 and pkt_error = 1 every such cycle.
  - Resume when data reappears.

General rules:
- rsp_rd and dat_rd are never asserted in the same cycle.
- Each payload byte produces at most one dat_rd.
- Descriptor lengths above MAX_LEN are never truncated; they are dropped.

## Timing
Reset values: tx_valid = 0, tx_data = 0x00, rsp_rd = 0, dat_rd = 0, busy = 0, pkt_error = 0, state = IDLE, counters = 0.

Reset mid-packet:
- The packet is abandoned and the block is in IDLE on the next cycle.
- Popped data is not recovered. The FIFOs must be reset together with this block.

Handshake:
- Once tx_valid rises, tx_valid and tx_data stay constant until the transfer.
- FWFT dat_byte is stable because no pop happens before the transfer.

Latency and throughput:
- Eligible descriptor in cycle N → rsp_rd in cycle N → header valid in cycle N+1.
- With tx_ready held high, header and payload go out at 1 byte/cycle. A packet of length L occupies cycles N+1 … N+1+L.
- After the last transfer in cycle M, the next header is valid at M+2 at the earliest (one IDLE cycle).

Outputs:
- tx_data/tx_valid are decoded combinationally from the state register and latched fields.
- dat_rd is a combinational function of state and tx_ready.
- No combinational path from tx_ready to rsp_rd.

## Structure
- Shared package uart_pkt_pkg, also imported by the parser:
  - Constants HDR_INSTR_W = 4, HDR_LEN_W = 4, MAX_PAYLOAD = 15.
  - Builder state enum.
  - Functions hdr_pack(instr, len) and hdr_unpack.
- Single module, no sub-modules: the datapath is one byte mux and one 4-bit down-counter.

## Test plan
- Descriptor instr = 0xA, len = 0, tx_ready = 1 → one rsp_rd, a single beat 0xA0, no dat_rd, busy high for 1 cycle.
- instr = 0x5, len = 3, data 0x11 0x22 0x33 → beats 0x53 0x11 0x22 0x33 in four consecutive cycles, three dat_rd pulses, state IDLE afterwards.
- Same packet with tx_ready toggling 1-0-0-1 → tx_data held stable while stalled, four transfers total, no duplicate dat_rd.
- len = 4 with dat_count = 2 → no rsp_rd and tx_valid = 0 until dat_count reaches 4, then header 0x?4 on the next cycle.
- rsp_len = 20 → rsp_rd and pkt_error pulse together, no tx_valid, no dat_rd, next descriptor processed normally.
- rst asserted during the second payload byte → all outputs 0 on the next cycle, busy = 0, a fresh descriptor is served correctly afterwards.
